// File: rtl/hc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hc_pkg
//  Description : Shared constants, state encoding and LFSR step function for
//                the Hamming-code test-pattern burst scheduler.
//                Contents:
//                  LFSR_W, LFSR_RST       register width and reset value
//                  TAP_A..TAP_D           feedback tap positions (15,14,12,3)
//                  state_t                scheduler states IDLE/RUN/GAP/DONE
//                  lfsr_next()            one step of the 16-bit LFSR
//  Revision    : 1.0 - initial release
// ============================================================================
package hc_pkg;

    localparam int          LFSR_W   = 16;
    localparam logic [15:0] LFSR_RST = 16'h0001;

    localparam int TAP_A = 15;
    localparam int TAP_B = 14;
    localparam int TAP_C = 12;
    localparam int TAP_D = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    // The NOR term forces a 1 into the shift-in position whenever all taps
    // are zero, so the all-zero state (e.g. a zero seed) escapes to 0x0001
    // instead of locking up.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] r);
        logic w_fb;
        logic w_zero;
        w_fb   = r[TAP_A] ^ r[TAP_B] ^ r[TAP_C] ^ r[TAP_D];
        w_zero = ~(r[TAP_A] | r[TAP_B] | r[TAP_C] | r[TAP_D]);
        return {r[LFSR_W-2:0], w_fb | w_zero};
    endfunction

endpackage : hc_pkg
`default_nettype wire

// File: rtl/hc_lfsr16.sv
`default_nettype none
// ============================================================================
//  Module      : hc_lfsr16
//  Description : 16-bit test-pattern LFSR register with synchronous load.
//  Ports       :
//    clk       in   1   clock, rising edge
//    rst       in   1   asynchronous active-high reset (q -> LFSR_RST)
//    en        in   1   advance one step
//    load      in   1   load load_val (takes priority over en)
//    load_val  in   16  value to load
//    q         out  16  current LFSR state
//  Revision    : 1.0 - initial release
// ============================================================================
module hc_lfsr16
    import hc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= LFSR_RST;
        end else if (load) begin
            r_q <= load_val;
        end else if (en) begin
            r_q <= lfsr_next(r_q);
        end
    end

    assign q = r_q;

endmodule : hc_lfsr16
`default_nettype wire

// File: rtl/hc_lfsr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : hc_lfsr_sched
//  Description : Burst scheduler for the 16-bit Hamming-code test-pattern
//                LFSR. Seeds the LFSR, offers a counted burst of words over a
//                valid/ready handshake (stepping only on accepted transfers),
//                inserts optional idle gaps, supports abort and pulses done.
//  Parameters  :
//    LEN_W       width of burst_len / word_idx
//    GAP_CYCLES  idle cycles forced between accepted words (0 = none)
//  Ports       :
//    clk, rst    clock (rising edge), asynchronous active-high reset
//    seed_load   load seed into LFSR (IDLE only)
//    seed        seed value
//    start       begin burst (IDLE only)
//    burst_len   words in burst, sampled on start
//    abort       terminate burst early (RUN/GAP)
//    word        data word offered (current LFSR state)
//    word_valid  word offered
//    word_ready  encoder accepts word
//    word_idx    words accepted in current burst
//    busy        high in RUN/GAP/DONE
//    done        one-cycle pulse at burst end
//  Revision    : 1.0 - initial release
// ============================================================================
module hc_lfsr_sched
    import hc_pkg::*;
#(
    parameter int LEN_W      = 8,
    parameter int GAP_CYCLES = 0
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              start,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic              abort,
    output logic [LFSR_W-1:0] word,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [LEN_W-1:0]  word_idx,
    output logic              busy,
    output logic              done
);

    // Gap counter is sized to hold GAP_CYCLES; kept at least one bit wide so
    // the back-to-back configuration still elaborates cleanly.
    localparam int              GAP_W      = $clog2(GAP_CYCLES + 2);
    localparam logic [GAP_W-1:0] c_gap_init = GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [LEN_W-1:0]  r_rem;
    logic [LEN_W-1:0]  r_idx;
    logic [GAP_W-1:0]  r_gap;
    logic              w_xfer;
    logic              w_seed_load;
    logic [LFSR_W-1:0] w_lfsr_q;

    assign w_xfer      = (r_state == RUN) && word_ready;
    assign w_seed_load = (r_state == IDLE) && seed_load;

    hc_lfsr16 u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .en       (w_xfer),
        .load     (w_seed_load),
        .load_val (seed),
        .q        (w_lfsr_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = (burst_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // A transfer coinciding with abort still counts; both the
                // last-word and abort paths land in DONE.
                if (w_xfer && (r_rem == LEN_W'(1))) begin
                    w_state_nxt = DONE;
                end else if (abort) begin
                    w_state_nxt = DONE;
                end else if (w_xfer && (GAP_CYCLES > 0)) begin
                    w_state_nxt = GAP;
                end
            end
            GAP: begin
                if (abort) begin
                    w_state_nxt = DONE;
                end else if (r_gap == '0) begin
                    w_state_nxt = RUN;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Remaining-word, accepted-word and gap counters. word_idx is only
    // cleared on start so it keeps the final count visible after DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem <= '0;
            r_idx <= '0;
            r_gap <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_rem <= burst_len;
                        r_idx <= '0;
                    end
                end
                RUN: begin
                    if (w_xfer) begin
                        r_rem <= r_rem - LEN_W'(1);
                        r_idx <= r_idx + LEN_W'(1);
                        r_gap <= c_gap_init;
                    end
                end
                GAP: begin
                    if (r_gap != '0) begin
                        r_gap <= r_gap - GAP_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign word       = w_lfsr_q;
    assign word_valid = (r_state == RUN);
    assign word_idx   = r_idx;
    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE);

endmodule : hc_lfsr_sched
`default_nettype wire

// File: tb/tb_hc_lfsr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hc_lfsr_sched
//  Description : Self-checking bench for hc_lfsr_sched. One instance runs
//                back-to-back (GAP_CYCLES=0), a second uses GAP_CYCLES=2.
//                Expected words come from a transaction-level LFSR model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hc_lfsr_sched;

    localparam int LEN_W = 8;
    localparam int G     = 2;

    logic              clk = 1'b0;
    logic              rst;

    logic              seed_load, start, abort, word_ready;
    logic [15:0]       seed;
    logic [LEN_W-1:0]  burst_len;
    logic [15:0]       word;
    logic              word_valid, busy, done;
    logic [LEN_W-1:0]  word_idx;

    logic              g_seed_load, g_start, g_abort, g_ready;
    logic [15:0]       g_seed;
    logic [LEN_W-1:0]  g_burst_len;
    logic [15:0]       g_word;
    logic              g_word_valid, g_busy, g_done;
    logic [LEN_W-1:0]  g_word_idx;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_lfsr;
    logic [15:0] g_lfsr;

    hc_lfsr_sched #(.LEN_W(LEN_W), .GAP_CYCLES(0)) u_dut (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .start(start),
        .burst_len(burst_len), .abort(abort), .word(word), .word_valid(word_valid),
        .word_ready(word_ready), .word_idx(word_idx), .busy(busy), .done(done)
    );

    hc_lfsr_sched #(.LEN_W(LEN_W), .GAP_CYCLES(G)) u_dut_gap (
        .clk(clk), .rst(rst), .seed_load(g_seed_load), .seed(g_seed), .start(g_start),
        .burst_len(g_burst_len), .abort(g_abort), .word(g_word), .word_valid(g_word_valid),
        .word_ready(g_ready), .word_idx(g_word_idx), .busy(g_busy), .done(g_done)
    );

    always #5 clk = ~clk;

    // Reference LFSR step written arithmetically from the polynomial rule.
    function automatic logic [15:0] ref_step(input logic [15:0] x);
        int v, fb, z;
        v  = int'(x);
        fb = ((v >> 15) ^ (v >> 14) ^ (v >> 12) ^ (v >> 3)) & 1;
        z  = ((v & 'hD008) == 0) ? 1 : 0;
        return 16'(((v << 1) & 'hFFFF) | fb | z);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one burst on the back-to-back instance. Entered and left on a
    // falling edge. stall_at/stall_len force ready low after that many
    // transfers; abort_at raises abort with ready on that transfer number;
    // junk_at drives start/seed_load mid-burst (must be ignored).
    task automatic do_burst(input int len, input bit load, input logic [15:0] sd,
                            input int pct, input int stall_at, input int stall_len,
                            input int abort_at, input int junk_at);
        int xfers  = 0;
        int stalls = 0;
        int guard  = 0;
        bit fin    = 0;
        bit junked = 0;
        bit rdy;
        seed_load  = load;
        seed       = sd;
        start      = 1'b1;
        burst_len  = LEN_W'(len);
        word_ready = 1'b0;
        abort      = 1'b0;
        if (load) m_lfsr = sd;
        @(negedge clk);
        start     = 1'b0;
        seed_load = 1'b0;
        seed      = 16'($urandom);
        if (len == 0) fin = 1;
        while (!fin) begin
            check("run_valid", 32'(word_valid), 32'd1);
            check("run_word", 32'(word), 32'(m_lfsr));
            check("run_idx", 32'(word_idx), 32'(xfers));
            check("run_done", 32'(done), 32'd0);
            if (xfers == stall_at && stalls < stall_len) begin
                rdy = 1'b0;
                stalls++;
            end else begin
                rdy = ($urandom_range(99) < pct);
            end
            if (xfers + 1 == abort_at) begin
                rdy   = 1'b1;
                abort = 1'b1;
            end
            if (xfers == junk_at && !junked) begin
                junked    = 1;
                start     = 1'b1;
                seed_load = 1'b1;
                seed      = 16'($urandom);
                burst_len = LEN_W'($urandom);
            end
            word_ready = rdy;
            @(negedge clk);
            abort      = 1'b0;
            start      = 1'b0;
            seed_load  = 1'b0;
            word_ready = 1'b0;
            if (rdy) begin
                m_lfsr = ref_step(m_lfsr);
                xfers++;
                if (xfers == len || xfers == abort_at) fin = 1;
            end
            guard++;
            if (guard > 500 && !fin) begin
                checks++;
                errors++;
                $error("FAIL burst_timeout: observed %0d transfers expected %0d", xfers, len);
                fin = 1;
            end
        end
        check("done_pulse", 32'(done), 32'd1);
        check("done_valid", 32'(word_valid), 32'd0);
        check("done_idx", 32'(word_idx), 32'(xfers));
        check("done_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("idle_done", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_valid", 32'(word_valid), 32'd0);
        check("idle_idx", 32'(word_idx), 32'(xfers));
        check("idle_word", 32'(word), 32'(m_lfsr));
    endtask

    initial begin
        rst = 1'b1;
        seed_load = 0; start = 0; abort = 0; word_ready = 0; seed = '0; burst_len = '0;
        g_seed_load = 0; g_start = 0; g_abort = 0; g_ready = 0; g_seed = '0; g_burst_len = '0;
        m_lfsr = 16'h0001;
        g_lfsr = 16'h0001;
        #2;
        check("rst_valid", 32'(word_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_idx", 32'(word_idx), 32'd0);
        check("rst_word", 32'(word), 32'h0001);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back burst of 4 from reset: 0001,0003,0007,000F.
        do_burst(4, 0, 16'h0, 100, -1, 0, -1, -1);
        // Stall three cycles after the second transfer.
        do_burst(4, 0, 16'h0, 100, 2, 3, -1, -1);
        // Seeded bursts, including the all-zero seed escape.
        do_burst(2, 1, 16'h8000, 100, -1, 0, -1, -1);
        do_burst(2, 1, 16'h0000, 100, -1, 0, -1, -1);
        // Abort on the third transfer of an 8-word burst; zero-length burst.
        do_burst(8, 0, 16'h0, 100, -1, 0, 3, -1);
        do_burst(0, 0, 16'h0, 100, -1, 0, -1, -1);
        // start/seed_load during RUN must be ignored.
        do_burst(6, 0, 16'h0, 100, -1, 0, -1, 2);

        // Randomized bursts.
        for (int i = 0; i < 12; i++) begin
            do_burst(int'($urandom_range(12)), 1'($urandom), 16'($urandom),
                     int'($urandom_range(100, 30)), int'($urandom_range(5)),
                     int'($urandom_range(3)),
                     ($urandom_range(3) == 0) ? int'($urandom_range(6, 1)) : -1,
                     int'($urandom_range(8)));
        end

        // Gap instance: valid one cycle, low G cycles, repeating.
        g_start     = 1'b1;
        g_burst_len = LEN_W'(3);
        g_ready     = 1'b1;
        @(negedge clk);
        g_start = 1'b0;
        for (int k = 0; k < 3 * (G + 1) - G; k++) begin
            check("gap_valid", 32'(g_word_valid), 32'((k % (G + 1)) == 0));
            check("gap_done", 32'(g_done), 32'd0);
            if ((k % (G + 1)) == 0) begin
                check("gap_word", 32'(g_word), 32'(g_lfsr));
                g_lfsr = ref_step(g_lfsr);
            end
            @(negedge clk);
        end
        check("gap_done_pulse", 32'(g_done), 32'd1);
        check("gap_done_idx", 32'(g_word_idx), 32'd3);
        g_ready = 1'b0;
        @(negedge clk);

        // Asynchronous reset mid-RUN.
        start      = 1'b1;
        burst_len  = LEN_W'(10);
        @(negedge clk);
        start      = 1'b0;
        word_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_valid", 32'(word_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(word_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_idx", 32'(word_idx), 32'd0);
        check("arst_word", 32'(word), 32'h0001);
        word_ready = 1'b0;
        @(negedge clk);
        rst    = 1'b0;
        m_lfsr = 16'h0001;
        do_burst(3, 0, 16'h0, 100, -1, 0, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_hc_lfsr_sched
`default_nettype wire
